// File: rtl/pll_seq_pkg.sv
// Shared constants for the PLL reset sequencer: FSM state encoding, reference-clock
// derived default timings and the small saturating counter helper.
package pll_seq_pkg;

    localparam logic [2:0] S_PLL_RST   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RELEASE   = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAULT     = 3'd5;

    localparam int CYC_PER_US        = 25;
    localparam int DEF_LOCK_TIMEOUT  = 1000 * CYC_PER_US;
    localparam int DEF_STABLE_CYCLES = 100 * CYC_PER_US;

    localparam int CNT8_W = 8;

    function automatic logic [CNT8_W-1:0] sat_inc8(input logic [CNT8_W-1:0] v,
                                                   input logic [CNT8_W-1:0] lim);
        return (v < lim) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Generic 1-bit two-flop synchronizer with synchronous active-low reset to 0.
module pll_lock_sync (
    input  logic clock,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL power-up/lock sequencer with staged sys/panel reset release on the 25 MHz ref clock.
// Optional macro PLL_RETRY_LIMIT_EN: enter a sticky fault state after MAX_RETRIES lock timeouts.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int STAGGER_CYCLES = 8,
    parameter int MAX_RETRIES    = 7,
    parameter int CNT_W          = 16
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              pll_locked,
    output logic              pll_rst,
    output logic              sys_rst_n,
    output logic              panel_rst_n,
    output logic              ready,
    output logic              fault,
    output logic [CNT8_W-1:0] lock_loss_count,
    output logic [2:0]        state
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first sees lock already counts as one stable cycle.
    localparam logic [CNT_W-1:0] STABLE_LAST  =
        CNT_W'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT8_W-1:0] RETRY_LIM   = CNT8_W'(MAX_RETRIES);
    localparam logic [CNT8_W-1:0] COUNT_MAX   = {CNT8_W{1'b1}};

    logic              lock_s;
    logic [CNT_W-1:0]  timer;
    logic [CNT8_W-1:0] retries;

    pll_lock_sync u_lock_sync (
        .clock (clock),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state           <= S_PLL_RST;
            timer           <= '0;
            retries         <= '0;
            pll_rst         <= 1'b1;
            sys_rst_n       <= 1'b0;
            panel_rst_n     <= 1'b0;
            ready           <= 1'b0;
            lock_loss_count <= '0;
        end else begin
            case (state)
                S_PLL_RST: begin
                    pll_rst     <= 1'b1;
                    sys_rst_n   <= 1'b0;
                    panel_rst_n <= 1'b0;
                    ready       <= 1'b0;
                    if (timer == RST_LAST) begin
                        state   <= S_WAIT_LOCK;
                        timer   <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= S_STABLE;
                        timer <= '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        timer   <= '0;
                        pll_rst <= 1'b1;
                        retries <= sat_inc8(retries, RETRY_LIM);
`ifdef PLL_RETRY_LIMIT_EN
                        if (retries + 1'b1 == RETRY_LIM)
                            state <= S_FAULT;
                        else
                            state <= S_PLL_RST;
`else
                        state <= S_PLL_RST;
`endif
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state <= S_WAIT_LOCK;
                        timer <= '0;
                    end else if (timer == STABLE_LAST) begin
                        state     <= S_RELEASE;
                        timer     <= '0;
                        sys_rst_n <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RELEASE, S_RUN: begin
                    // Lock loss takes priority over stagger completion.
                    if (!lock_s) begin
                        state       <= S_PLL_RST;
                        timer       <= '0;
                        pll_rst     <= 1'b1;
                        sys_rst_n   <= 1'b0;
                        panel_rst_n <= 1'b0;
                        ready       <= 1'b0;
                        if (state == S_RUN)
                            lock_loss_count <= sat_inc8(lock_loss_count, COUNT_MAX);
                    end else if (state == S_RELEASE) begin
                        if (timer == STAGGER_LAST) begin
                            state       <= S_RUN;
                            timer       <= '0;
                            panel_rst_n <= 1'b1;
                            ready       <= 1'b1;
                            retries     <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                S_FAULT: begin
                    pll_rst     <= 1'b1;
                    sys_rst_n   <= 1'b0;
                    panel_rst_n <= 1'b0;
                    ready       <= 1'b0;
`ifndef PLL_RETRY_LIMIT_EN
                    state <= S_PLL_RST;
                    timer <= '0;
`endif
                end
                default: begin
                    state       <= S_PLL_RST;
                    timer       <= '0;
                    pll_rst     <= 1'b1;
                    sys_rst_n   <= 1'b0;
                    panel_rst_n <= 1'b0;
                    ready       <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_RETRY_LIMIT_EN
    always_ff @(posedge clock) begin
        if (!rst_n)
            fault <= 1'b0;
        else if (state == S_WAIT_LOCK && !lock_s && timer == TIMEOUT_LAST
                 && retries + 1'b1 == RETRY_LIM)
            fault <= 1'b1;
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timings; honours PLL_RETRY_LIMIT_EN.
module tb_pll_reset_sequencer;

    localparam int I_PLL_RST = 0;
    localparam int I_SYS     = 1;
    localparam int I_PANEL   = 2;
    localparam int I_READY   = 3;
    localparam int I_STATE   = 4;

    logic       clock;
    logic       rst_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       panel_rst_n;
    logic       ready;
    logic       fault;
    logic [7:0] lock_loss_count;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    pll_reset_sequencer #(
        .RST_CYCLES     (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (10),
        .STAGGER_CYCLES (3),
        .MAX_RETRIES    (2),
        .CNT_W          (16)
    ) dut (
        .clock           (clock),
        .rst_n           (rst_n),
        .pll_locked      (pll_locked),
        .pll_rst         (pll_rst),
        .sys_rst_n       (sys_rst_n),
        .panel_rst_n     (panel_rst_n),
        .ready           (ready),
        .fault           (fault),
        .lock_loss_count (lock_loss_count),
        .state           (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int sig(input int idx);
        case (idx)
            I_PLL_RST: return int'(pll_rst);
            I_SYS:     return int'(sys_rst_n);
            I_PANEL:   return int'(panel_rst_n);
            I_READY:   return int'(ready);
            default:   return int'(state);
        endcase
    endfunction

    // Number of clock edges until the signal takes the value; -1 if the bound expires.
    task automatic edges_until(input int idx, input int val, input int bound, output int n);
        n = 0;
        while (sig(idx) != val && n < bound) begin
            @(negedge clock);
            n++;
        end
        if (sig(idx) != val) n = -1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst"}, int'(pll_rst), 1);
        chk({tag, "_sys"}, int'(sys_rst_n), 0);
        chk({tag, "_panel"}, int'(panel_rst_n), 0);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_fault"}, int'(fault), 0);
        chk({tag, "_cnt"}, int'(lock_loss_count), 0);
        chk({tag, "_state"}, int'(state), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int tmo;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        repeat (3) @(negedge clock);
        chk_reset_vals("reset");

        // Clean start
        rst_n = 1'b1;
        edges_until(I_PLL_RST, 0, 50, n);
        chk("start_pll_rst_len", n, 4);
        chk("start_wait_state", int'(state), 1);
        @(negedge clock);
        pll_locked = 1'b1;
        edges_until(I_SYS, 1, 100, n);
        chk("start_sys_delay", n, 12);
        chk("start_release_state", int'(state), 3);
        chk("start_panel_held", int'(panel_rst_n), 0);
        edges_until(I_PANEL, 1, 20, n);
        chk("start_stagger", n, 3);
        chk("start_ready", int'(ready), 1);
        chk("start_run_state", int'(state), 4);
        chk("start_cnt", int'(lock_loss_count), 0);
        repeat (4) @(negedge clock);
        chk("run_hold_ready", int'(ready), 1);

        // Lock loss in RUN
        pll_locked = 1'b0;
        edges_until(I_SYS, 0, 20, n);
        chk("loss_sys_delay", n, 3);
        chk("loss_panel", int'(panel_rst_n), 0);
        chk("loss_ready", int'(ready), 0);
        chk("loss_cnt", int'(lock_loss_count), 1);
        chk("loss_state", int'(state), 0);
        chk("loss_pll_rst", int'(pll_rst), 1);

        // Glitch during STABLE
        pll_locked = 1'b1;
        edges_until(I_STATE, 2, 50, n);
        chk("glitch_reach_stable", n, 5);
        repeat (5) @(negedge clock);
        pll_locked = 1'b0;
        @(negedge clock);
        pll_locked = 1'b1;
        repeat (2) @(negedge clock);
        chk("glitch_back_wait", int'(state), 1);
        chk("glitch_sys_low", int'(sys_rst_n), 0);
        edges_until(I_SYS, 1, 50, n);
        chk("glitch_full_restart", n, 10);
        edges_until(I_PANEL, 1, 20, n);
        chk("glitch_stagger", n, 3);
        chk("glitch_ready", int'(ready), 1);

        // Lock loss during the stagger window
        pll_locked = 1'b0;
        edges_until(I_SYS, 0, 20, n);
        chk("loss2_sys_delay", n, 3);
        chk("loss2_cnt", int'(lock_loss_count), 2);
        pll_locked = 1'b1;
        edges_until(I_SYS, 1, 60, n);
        chk("relock_sys_delay", n, 14);
        pll_locked = 1'b0;
        @(negedge clock);
        chk("stag_panel_r1", int'(panel_rst_n), 0);
        @(negedge clock);
        chk("stag_panel_r2", int'(panel_rst_n), 0);
        chk("stag_state_r2", int'(state), 3);
        @(negedge clock);
        chk("stag_sys", int'(sys_rst_n), 0);
        chk("stag_panel", int'(panel_rst_n), 0);
        chk("stag_ready", int'(ready), 0);
        chk("stag_cnt", int'(lock_loss_count), 2);
        chk("stag_state", int'(state), 0);

        // Reach RUN with lock_loss_count=3, then reset
        pll_locked = 1'b1;
        edges_until(I_READY, 1, 60, n);
        chk("run3a_ready_delay", n, 17);
        pll_locked = 1'b0;
        edges_until(I_SYS, 0, 20, n);
        chk("loss3_sys_delay", n, 3);
        chk("loss3_cnt", int'(lock_loss_count), 3);
        pll_locked = 1'b1;
        edges_until(I_READY, 1, 60, n);
        chk("run3b_ready_delay", n, 17);
        rst_n = 1'b0;
        @(negedge clock);
        chk_reset_vals("midrst");
        rst_n = 1'b1;
        edges_until(I_PLL_RST, 0, 50, n);
        chk("midrst_repulse_len", n, 4);
        edges_until(I_SYS, 1, 60, n);
        chk("midrst_sys_delay", n, 10);
        edges_until(I_READY, 1, 20, n);
        chk("midrst_ready_delay", n, 3);

        // 300 lock losses saturate the counter
        tmo = 0;
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            edges_until(I_SYS, 0, 10, n);
            if (n < 0) tmo++;
            pll_locked = 1'b1;
            edges_until(I_READY, 1, 60, n);
            if (n < 0) tmo++;
        end
        chk("sat_loop_timeouts", tmo, 0);
        chk("sat_cnt", int'(lock_loss_count), 255);

        // Never locks
        pll_locked = 1'b0;
        edges_until(I_SYS, 0, 20, n);
        chk("nolock_sys_delay", n, 3);
        chk("nolock_cnt_sat", int'(lock_loss_count), 255);
        edges_until(I_PLL_RST, 0, 20, n);
        chk("nolock_pulse1", n, 4);
        edges_until(I_PLL_RST, 1, 50, n);
        chk("nolock_timeout1", n, 20);
        chk("nolock_state1", int'(state), 0);
        edges_until(I_PLL_RST, 0, 20, n);
        chk("nolock_pulse2", n, 4);
        edges_until(I_PLL_RST, 1, 50, n);
        chk("nolock_timeout2", n, 20);
`ifdef PLL_RETRY_LIMIT_EN
        chk("fault_state", int'(state), 5);
        chk("fault_flag", int'(fault), 1);
        repeat (30) @(negedge clock);
        chk("fault_state_hold", int'(state), 5);
        chk("fault_flag_hold", int'(fault), 1);
        chk("fault_pll_rst_hold", int'(pll_rst), 1);
        chk("fault_sys", int'(sys_rst_n), 0);
        chk("fault_ready", int'(ready), 0);
`else
        chk("nofault_state2", int'(state), 0);
        chk("nofault_flag", int'(fault), 0);
        edges_until(I_PLL_RST, 0, 20, n);
        chk("nolock_pulse3", n, 4);
        edges_until(I_PLL_RST, 1, 50, n);
        chk("nolock_timeout3", n, 20);
        chk("nofault_flag_end", int'(fault), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sequences the board PLL (25 MHz in; 150 MHz system clock and 40 MHz panel clock out) from power-up to run.
- Pulses the PLL reset and waits for lock with a timeout and retry.
- Qualifies lock as stable before staged release of the system-domain and panel-domain resets.
- Tears everything down on lock loss. Runs on the free-running 25 MHz reference clock, so it stays alive while the PLL is unlocked.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per PLL reset pulse.
- LOCK_TIMEOUT, 25000: cycles to wait for lock after the PLL reset pulse (1 ms at 25 MHz).
- STABLE_CYCLES, 2500: consecutive synchronized-lock-high cycles required before release (100 us).
- STAGGER_CYCLES, 8: cycles between sys_rst_n release and panel_rst_n release.
- MAX_RETRIES, 7: lock-timeout count that triggers fault. Used only with the optional feature.
- CNT_W, 16: width of the shared timer. Must hold max(LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- clock, input, 1: 25 MHz reference clock.
- rst_n, input, 1: synchronous active-low reset.
- pll_locked, input, 1: raw PLL LOCK output, asynchronous to clock.
- pll_rst, output, 1: drives the PLL RST input, active-high.
- sys_rst_n, output, 1: reset request for the 150 MHz domain. The consumer re-synchronizes it.
- panel_rst_n, output, 1: reset request for the 40 MHz panel domain. The consumer re-synchronizes it.
- ready, output, 1: high when the sequence is complete and lock is held.
- fault, output, 1: sticky retry-exhaustion flag. Constant 0 without the optional feature.
- lock_loss_count, output, 8: number of lock losses after ready, saturating.
- state, output, 3: current FSM state, for debug.

Behaviour:
- All logic is clocked by clock. Reset is synchronous and active-low.
- Reset values: pll_rst=1, sys_rst_n=0, panel_rst_n=0, ready=0, fault=0, lock_loss_count=0, timer=0, retries=0, state=S_PLL_RST.
- pll_locked passes through a 2-flop synchronizer to form lock_s. lock_s lags pll_locked by 2 clock edges.
- All outputs are registered.
- S_PLL_RST:
  - pll_rst=1; sys/panel resets asserted; timer counts.
  - Exactly RST_CYCLES cycles with pll_rst=1, then move to S_WAIT_LOCK with timer cleared.
- S_WAIT_LOCK:
  - pll_rst=0.
  - lock_s=1: move to S_STABLE, timer cleared.
  - Otherwise the timer increments. When timer==LOCK_TIMEOUT-1 with lock_s=0, move to S_PLL_RST and increment retries (saturating).
- S_STABLE:
  - lock_s=0 on any cycle: back to S_WAIT_LOCK, timer cleared. The timeout restarts in full.
  - After STABLE_CYCLES consecutive lock_s=1 cycles: move to S_RELEASE.
- S_RELEASE:
  - sys_rst_n=1 on the first cycle in state; timer counts.
  - After STAGGER_CYCLES cycles: panel_rst_n=1 and ready=1 together, move to S_RUN, retries cleared.
- S_RUN: outputs hold while lock_s=1.
- Lock loss (lock_s=0 in S_RELEASE or S_RUN), on the next edge:
  - sys_rst_n=0, panel_rst_n=0, ready=0.
  - lock_loss_count increments (saturates at 255; counts only losses from S_RUN).
  - Move to S_PLL_RST.
  - Same-cycle events resolve with lock loss winning over stagger completion.
- Reset mid-operation: rst_n low on any cycle returns every register to its reset value on that edge, including lock_loss_count. The PLL is re-pulsed after reset.
- Resets are never released out of order: panel_rst_n is never 1 while sys_rst_n is 0. pll_rst is 1 only in S_PLL_RST.
- State encoding: S_PLL_RST=0, S_WAIT_LOCK=1, S_STABLE=2, S_RELEASE=3, S_RUN=4, S_FAULT=5.

Optional Feature:
- Macro: PLL_RETRY_LIMIT_EN.
- Defined:
  - A timeout that would make retries==MAX_RETRIES enters S_FAULT instead of S_PLL_RST.
  - S_FAULT: fault=1, pll_rst=1, sys/panel resets asserted, ready=0. Exit only via rst_n.
- Undefined:
  - Retries repeat indefinitely and S_FAULT is unreachable.
  - fault is tied to 0. The retries counter may be optimized out.

Decomposition:
- Package pll_seq_pkg:
  - State encoding constants.
  - Default timing constants derived from the 25 MHz reference: CYC_PER_US=25.
  - Counter width 8 for lock_loss_count and retries.
- Sub-module pll_lock_sync: generic 2-flop synchronizer (1 bit, reset to 0). It is reused later for the re-synchronizers in the 150 MHz and 40 MHz domains.

Test Plan (bench parameters RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=10, STAGGER_CYCLES=3, MAX_RETRIES=2):
- Clean start: locked rises 5 cycles after rst_n release.
  - pll_rst high exactly 4 cycles.
  - sys_rst_n rises 10 cycles after lock_s.
  - panel_rst_n and ready rise 3 cycles later.
  - lock_loss_count=0.
- Lock glitch during S_STABLE: locked drops for 1 cycle after 6 stable cycles.
  - Returns to S_WAIT_LOCK.
  - Release is delayed a full 10 cycles from re-lock.
  - sys_rst_n never rises early.
- Never locks: pll_locked held 0.
  - pll_rst pulses of 4 cycles repeat every 4+20 cycles.
  - With PLL_RETRY_LIMIT_EN: S_FAULT after the 2nd timeout, with fault=1 and pll_rst=1 held. Without it: pulses continue indefinitely.
- Lock loss in S_RUN: drop locked.
  - sys_rst_n, panel_rst_n and ready are low 3 edges after the drop.
  - lock_loss_count=1; new pll_rst pulse.
  - Repeat 300 times: lock_loss_count saturates at 255.
- Lock loss during S_RELEASE stagger: drop at stagger cycle 2.
  - panel_rst_n never rises; ready stays 0; lock_loss_count unchanged.
- rst_n asserted in S_RUN with lock_loss_count=3: on that edge, all outputs return to their reset values and lock_loss_count=0.
